// File: rtl/decode_queue_pkg.sv
// Shared decode constants, control/exception field layout and queue FSM encoding.
// Optional feature macro: DECQ_MUL_EN (SPECIAL2 MUL accepted as an ALU R-type op).
package decode_queue_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned CTRL_W  = 12;
   localparam int unsigned EXC_W   = 4;

   // Control field bit positions, MSB first
   localparam int unsigned CTRL_REGWRITE  = 11;
   localparam int unsigned CTRL_REGDST_HI = 10;
   localparam int unsigned CTRL_REGDST_LO = 9;
   localparam int unsigned CTRL_ALUSRC    = 8;
   localparam int unsigned CTRL_BRANCH    = 7;
   localparam int unsigned CTRL_MEMWRITE  = 6;
   localparam int unsigned CTRL_MEMTOREG  = 5;
   localparam int unsigned CTRL_JUMP      = 4;
   localparam int unsigned CTRL_HILO      = 3;
   localparam int unsigned CTRL_JBRAL     = 2;
   localparam int unsigned CTRL_JR        = 1;
   localparam int unsigned CTRL_CP0WRITE  = 0;

   // Exception bit indices
   localparam int unsigned EXC_INVALID = 3;
   localparam int unsigned EXC_SYSCALL = 2;
   localparam int unsigned EXC_BRK     = 1;
   localparam int unsigned EXC_ERET    = 0;

   // Control encodings per instruction class
   localparam logic [CTRL_W-1:0] CTRL_NONE   = 12'b0_00_000000000;
   localparam logic [CTRL_W-1:0] CTRL_ALU_R  = 12'b1_01_000000000;
   localparam logic [CTRL_W-1:0] CTRL_HILOW  = 12'b0_00_000001000;
   localparam logic [CTRL_W-1:0] CTRL_JRX    = 12'b0_00_000000010;
   localparam logic [CTRL_W-1:0] CTRL_JALR   = 12'b1_01_000000110;
   localparam logic [CTRL_W-1:0] CTRL_ALU_I  = 12'b1_00_100000000;
   localparam logic [CTRL_W-1:0] CTRL_BR     = 12'b0_00_010000000;
   localparam logic [CTRL_W-1:0] CTRL_BRAL   = 12'b1_10_010000100;
   localparam logic [CTRL_W-1:0] CTRL_LOAD   = 12'b1_00_100100000;
   localparam logic [CTRL_W-1:0] CTRL_STORE  = 12'b0_00_101000000;
   localparam logic [CTRL_W-1:0] CTRL_J      = 12'b0_00_000010000;
   localparam logic [CTRL_W-1:0] CTRL_JAL    = 12'b1_10_000010100;
   localparam logic [CTRL_W-1:0] CTRL_MTC0   = 12'b0_00_000000001;
   localparam logic [CTRL_W-1:0] CTRL_MFC0   = 12'b1_00_000000000;

   // Opcodes
   localparam logic [5:0] OP_SPECIAL  = 6'b000000;
   localparam logic [5:0] OP_REGIMM   = 6'b000001;
   localparam logic [5:0] OP_J        = 6'b000010;
   localparam logic [5:0] OP_JAL      = 6'b000011;
   localparam logic [5:0] OP_BEQ      = 6'b000100;
   localparam logic [5:0] OP_BNE      = 6'b000101;
   localparam logic [5:0] OP_BLEZ     = 6'b000110;
   localparam logic [5:0] OP_BGTZ     = 6'b000111;
   localparam logic [5:0] OP_ADDI     = 6'b001000;
   localparam logic [5:0] OP_ADDIU    = 6'b001001;
   localparam logic [5:0] OP_SLTI     = 6'b001010;
   localparam logic [5:0] OP_SLTIU    = 6'b001011;
   localparam logic [5:0] OP_ANDI     = 6'b001100;
   localparam logic [5:0] OP_ORI      = 6'b001101;
   localparam logic [5:0] OP_XORI     = 6'b001110;
   localparam logic [5:0] OP_LUI      = 6'b001111;
   localparam logic [5:0] OP_COP0     = 6'b010000;
   localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
   localparam logic [5:0] OP_LB       = 6'b100000;
   localparam logic [5:0] OP_LH       = 6'b100001;
   localparam logic [5:0] OP_LW       = 6'b100011;
   localparam logic [5:0] OP_LBU      = 6'b100100;
   localparam logic [5:0] OP_LHU      = 6'b100101;
   localparam logic [5:0] OP_SB       = 6'b101000;
   localparam logic [5:0] OP_SH       = 6'b101001;
   localparam logic [5:0] OP_SW       = 6'b101011;

   // SPECIAL funct codes
   localparam logic [5:0] F_SLL     = 6'b000000;
   localparam logic [5:0] F_SRL     = 6'b000010;
   localparam logic [5:0] F_SRA     = 6'b000011;
   localparam logic [5:0] F_SLLV    = 6'b000100;
   localparam logic [5:0] F_SRLV    = 6'b000110;
   localparam logic [5:0] F_SRAV    = 6'b000111;
   localparam logic [5:0] F_JR      = 6'b001000;
   localparam logic [5:0] F_JALR    = 6'b001001;
   localparam logic [5:0] F_SYSCALL = 6'b001100;
   localparam logic [5:0] F_BREAK   = 6'b001101;
   localparam logic [5:0] F_MFHI    = 6'b010000;
   localparam logic [5:0] F_MTHI    = 6'b010001;
   localparam logic [5:0] F_MFLO    = 6'b010010;
   localparam logic [5:0] F_MTLO    = 6'b010011;
   localparam logic [5:0] F_MULT    = 6'b011000;
   localparam logic [5:0] F_MULTU   = 6'b011001;
   localparam logic [5:0] F_DIV     = 6'b011010;
   localparam logic [5:0] F_DIVU    = 6'b011011;
   localparam logic [5:0] F_ADD     = 6'b100000;
   localparam logic [5:0] F_ADDU    = 6'b100001;
   localparam logic [5:0] F_SUB     = 6'b100010;
   localparam logic [5:0] F_SUBU    = 6'b100011;
   localparam logic [5:0] F_AND     = 6'b100100;
   localparam logic [5:0] F_OR      = 6'b100101;
   localparam logic [5:0] F_XOR     = 6'b100110;
   localparam logic [5:0] F_NOR     = 6'b100111;
   localparam logic [5:0] F_SLT     = 6'b101010;
   localparam logic [5:0] F_SLTU    = 6'b101011;

   // SPECIAL2 / COP0 funct codes
   localparam logic [5:0] F_MUL     = 6'b000010;
   localparam logic [5:0] F_ERET    = 6'b011000;

   // REGIMM rt codes
   localparam logic [4:0] RT_BLTZ   = 5'b00000;
   localparam logic [4:0] RT_BGEZ   = 5'b00001;
   localparam logic [4:0] RT_BLTZAL = 5'b10000;
   localparam logic [4:0] RT_BGEZAL = 5'b10001;

   // COP0 rs codes
   localparam logic [4:0] RS_MFC0   = 5'b00000;
   localparam logic [4:0] RS_MTC0   = 5'b00100;
   localparam logic [4:0] RS_CO     = 5'b10000;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_BLOCK = 1'b1
   } state_e;

   // Decoded payload stored alongside each buffered instruction
   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [EXC_W-1:0]  exc;
   } dec_t;

endpackage

// File: rtl/decode_queue_instr_decode.sv
// Combinational MIPS32 decoder: instruction word to control field and exception flags.
// Optional feature macro: DECQ_MUL_EN (SPECIAL2 MUL decodes as ALU R-type).
module instr_decode
   import decode_queue_pkg::*;
(
   input  logic [INSTR_W-1:0] instr,
   output logic [CTRL_W-1:0]  ctrl,
   output logic [EXC_W-1:0]   exc
);

   logic [5:0] op;
   logic [5:0] funct;
   logic [4:0] rs;
   logic [4:0] rt;
   logic       hit;
   logic       unused_fields;

   assign op            = instr[31:26];
   assign rs            = instr[25:21];
   assign rt            = instr[20:16];
   assign funct         = instr[5:0];
   assign unused_fields = ^instr[15:6];

   // Classify the opcode; anything unmatched collapses to an invalid-instruction exception
   always_comb begin
      ctrl = CTRL_NONE;
      exc  = '0;
      hit  = 1'b1;
      case (op)
         OP_SPECIAL: begin
            case (funct)
               F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
               F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
               F_SLT, F_SLTU, F_MFHI, F_MFLO:         ctrl = CTRL_ALU_R;
               F_MULT, F_MULTU, F_DIV, F_DIVU,
               F_MTHI, F_MTLO:                         ctrl = CTRL_HILOW;
               F_JR:                                   ctrl = CTRL_JRX;
               F_JALR:                                 ctrl = CTRL_JALR;
               F_SYSCALL:                              exc[EXC_SYSCALL] = 1'b1;
               F_BREAK:                                exc[EXC_BRK] = 1'b1;
               default:                                hit = 1'b0;
            endcase
         end
         OP_REGIMM: begin
            case (rt)
               RT_BLTZ, RT_BGEZ:                       ctrl = CTRL_BR;
               RT_BLTZAL, RT_BGEZAL:                   ctrl = CTRL_BRAL;
               default:                                hit = 1'b0;
            endcase
         end
         OP_J:                                         ctrl = CTRL_J;
         OP_JAL:                                       ctrl = CTRL_JAL;
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:             ctrl = CTRL_BR;
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI:             ctrl = CTRL_ALU_I;
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:          ctrl = CTRL_LOAD;
         OP_SB, OP_SH, OP_SW:                          ctrl = CTRL_STORE;
         OP_COP0: begin
            if (rs == RS_MFC0)                         ctrl = CTRL_MFC0;
            else if (rs == RS_MTC0)                    ctrl = CTRL_MTC0;
            else if (rs == RS_CO && funct == F_ERET)   exc[EXC_ERET] = 1'b1;
            else                                       hit = 1'b0;
         end
`ifdef DECQ_MUL_EN
         OP_SPECIAL2: begin
            if (funct == F_MUL)                        ctrl = CTRL_ALU_R;
            else                                       hit = 1'b0;
         end
`endif
         default:                                      hit = 1'b0;
      endcase
      if (!hit) begin
         ctrl             = CTRL_NONE;
         exc              = '0;
         exc[EXC_INVALID] = 1'b1;
      end
   end

endmodule

// File: rtl/decode_queue.sv
// Decoded-instruction queue: circular buffer of decoded entries with a RUN/BLOCK gate
// that stops accepting after any excepting instruction until flushed.
// Optional feature macro: DECQ_MUL_EN (passed through to instr_decode).
module decode_queue
   import decode_queue_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,   // power of two, >= 2
   parameter int unsigned ADDR_W = 32
)(
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [INSTR_W-1:0]       in_instr,
   input  logic [ADDR_W-1:0]        in_pc,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [INSTR_W-1:0]       out_instr,
   output logic [ADDR_W-1:0]        out_pc,
   output logic [CTRL_W-1:0]        out_ctrl,
   output logic [EXC_W-1:0]         out_exc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   state_e              state_q, state_d;
   logic [PTR_W-1:0]    rd_q, rd_d;
   logic [PTR_W-1:0]    wr_q, wr_d;
   logic [CNT_W-1:0]    count_q, count_d;

   logic [INSTR_W-1:0]  instr_mem_q [DEPTH];
   logic [ADDR_W-1:0]   pc_mem_q    [DEPTH];
   dec_t                dec_mem_q   [DEPTH];

   logic [CTRL_W-1:0]   dec_ctrl_c;
   logic [EXC_W-1:0]    dec_exc_c;
   dec_t                dec_c;
   logic                push_c;
   logic                pop_c;

   instr_decode u_decode (
      .instr (in_instr),
      .ctrl  (dec_ctrl_c),
      .exc   (dec_exc_c)
   );

   assign dec_c.ctrl = dec_ctrl_c;
   assign dec_c.exc  = dec_exc_c;

   // Handshakes and head-of-queue view, all derived from registered state
   assign in_ready  = (state_q == ST_RUN) && (count_q < CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push_c    = in_valid && in_ready;
   assign pop_c     = out_valid && out_ready;
   assign out_instr = instr_mem_q[rd_q];
   assign out_pc    = pc_mem_q[rd_q];
   assign out_ctrl  = dec_mem_q[rd_q].ctrl;
   assign out_exc   = dec_mem_q[rd_q].exc;
   assign count     = count_q;

   // Next state for FSM, pointers and occupancy; flush overrides push and pop
   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q;
      if (flush) begin
         state_d = ST_RUN;
         rd_d    = '0;
         wr_d    = '0;
         count_d = '0;
      end else begin
         if (push_c) begin
            wr_d = wr_q + PTR_W'(1);
            if (dec_c.exc != '0) state_d = ST_BLOCK;
         end
         if (pop_c) rd_d = rd_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      end
   end

   // Control state registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_RUN;
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
      end
   end

   // Entry storage: instruction, PC and decode captured together on accept
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            instr_mem_q[i] <= '0;
            pc_mem_q[i]    <= '0;
            dec_mem_q[i]   <= '0;
         end
      end else if (push_c && !flush) begin
         instr_mem_q[wr_q] <= in_instr;
         pc_mem_q[wr_q]    <= in_pc;
         dec_mem_q[wr_q]   <= dec_c;
      end
   end

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue (DEPTH=4, ADDR_W=32).
// Honors DECQ_MUL_EN when selecting expectations for the SPECIAL2 MUL word.
module tb_decode_queue;

   logic        clk;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [11:0] out_ctrl;
   logic [3:0]  out_exc;
   logic [2:0]  count;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [31:0] I_ADDU = 32'h00851021;
   localparam logic [31:0] I_LW   = 32'h8C820004;
   localparam logic [31:0] I_BAD  = 32'h4C000000;
   localparam logic [31:0] I_MUL  = 32'h70851002;

   decode_queue #(.DEPTH(4), .ADDR_W(32)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .in_pc     (in_pc),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_pc    (out_pc),
      .out_ctrl  (out_ctrl),
      .out_exc   (out_exc),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      resetn = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
      flush = 1'b0; out_ready = 1'b0;
      #12;
      n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_checks++; if ({out_instr, out_pc, out_ctrl, out_exc} !== 80'h0) begin n_errors++;
         $display("FAIL reset_outs instr=%h pc=%h ctrl=%b exc=%b exp all zero", out_instr, out_pc, out_ctrl, out_exc); end
      @(negedge clk); resetn = 1'b1;
      tick;
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_addu;
      out_ready = 1'b1; in_valid = 1'b1; in_instr = I_ADDU; in_pc = 32'h0000_1000;
      tick;
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL addu_latency out_valid got=%b exp=1", out_valid); end
      n_checks++; if (out_ctrl !== 12'b1_01_000000000 || out_exc !== 4'b0000) begin n_errors++;
         $display("FAIL addu_decode ctrl=%b exc=%b exp ctrl=101000000000 exc=0000", out_ctrl, out_exc); end
      n_checks++; if (out_instr !== I_ADDU || out_pc !== 32'h0000_1000) begin n_errors++;
         $display("FAIL addu_payload instr=%h pc=%h exp %h 00001000", out_instr, out_pc, I_ADDU); end
      tick;
      n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL addu_pop count got=%0d exp=0", count); end
   endtask

   task automatic test_full;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_instr = I_LW; in_pc = 32'h0000_2000 + 32'(4 * i);
         tick;
      end
      in_valid = 1'b0;
      n_checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin n_errors++;
         $display("FAIL full_state count=%0d in_ready=%b exp 4 0", count, in_ready); end
      n_checks++; if (out_ctrl !== 12'b1_00_100100000) begin n_errors++;
         $display("FAIL full_lw_ctrl got=%b exp=100100100000", out_ctrl); end
      tick;
      n_checks++; if (out_pc !== 32'h0000_2000 || out_valid !== 1'b1) begin n_errors++;
         $display("FAIL full_hold pc=%h valid=%b exp 00002000 1", out_pc, out_valid); end
      // Push attempt while full and popping: must be refused
      in_valid = 1'b1; in_instr = I_ADDU; in_pc = 32'hDEAD_0000; out_ready = 1'b1;
      tick;
      in_valid = 1'b0;
      n_checks++; if (count !== 3'd3) begin n_errors++; $display("FAIL full_no_push count got=%0d exp=3", count); end
      for (int i = 1; i < 4; i++) begin
         n_checks++; if (out_pc !== 32'h0000_2000 + 32'(4 * i) || out_instr !== I_LW) begin n_errors++;
            $display("FAIL full_order_%0d pc=%h instr=%h exp %h %h", i, out_pc, out_instr, 32'h0000_2000 + 32'(4 * i), I_LW); end
         tick;
      end
      n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_errors++;
         $display("FAIL full_drained count=%0d valid=%b exp 0 0", count, out_valid); end
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ADDU; in_pc = 32'h0000_3000;
      tick;
      in_pc = 32'h0000_3004; out_ready = 1'b1;
      tick;
      in_valid = 1'b0;
      n_checks++; if (count !== 3'd1 || out_pc !== 32'h0000_3004) begin n_errors++;
         $display("FAIL b2b count=%0d pc=%h exp 1 00003004", count, out_pc); end
      tick;
      n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL b2b_drain count got=%0d exp=0", count); end
   endtask

   task automatic test_block;
      out_ready = 1'b0; in_valid = 1'b1; in_instr = I_BAD; in_pc = 32'h0000_4000;
      tick;
      n_checks++; if (out_exc !== 4'b1000 || out_ctrl !== 12'h000 || in_ready !== 1'b0) begin n_errors++;
         $display("FAIL block_enter exc=%b ctrl=%b in_ready=%b exp 1000 0 0", out_exc, out_ctrl, in_ready); end
      in_instr = I_ADDU;
      tick;
      in_valid = 1'b0;
      n_checks++; if (count !== 3'd1) begin n_errors++; $display("FAIL block_no_push count got=%0d exp=1", count); end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      n_checks++; if (count !== 3'd0 || in_ready !== 1'b0) begin n_errors++;
         $display("FAIL block_drain count=%0d in_ready=%b exp 0 0", count, in_ready); end
      flush = 1'b1;
      tick;
      flush = 1'b0;
      n_checks++; if (in_ready !== 1'b1 || count !== 3'd0) begin n_errors++;
         $display("FAIL block_flush in_ready=%b count=%0d exp 1 0", in_ready, count); end
   endtask

   task automatic test_flush_collision;
      out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ADDU;
      in_pc = 32'h0000_5000; tick;
      in_pc = 32'h0000_5004; tick;
      n_checks++; if (count !== 3'd2) begin n_errors++; $display("FAIL flushc_pre count got=%0d exp=2", count); end
      in_pc = 32'h0000_5008; out_ready = 1'b1; flush = 1'b1;
      tick;
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      n_checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_errors++;
         $display("FAIL flushc count=%0d valid=%b in_ready=%b exp 0 0 1", count, out_valid, in_ready); end
      tick;
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL flushc_lost valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_decode_table;
      logic [31:0] tw [11];
      logic [11:0] tc [11];
      logic [3:0]  te [11];
      tw[0]  = 32'h03E00008; tc[0]  = 12'b0_00_000000010; te[0]  = 4'b0000; // JR
      tw[1]  = 32'h0C000010; tc[1]  = 12'b1_10_000010100; te[1]  = 4'b0000; // JAL
      tw[2]  = 32'h04110004; tc[2]  = 12'b1_10_010000100; te[2]  = 4'b0000; // BGEZAL
      tw[3]  = 32'hAC820004; tc[3]  = 12'b0_00_101000000; te[3]  = 4'b0000; // SW
      tw[4]  = 32'h40846000; tc[4]  = 12'b0_00_000000001; te[4]  = 4'b0000; // MTC0
      tw[5]  = 32'h00850018; tc[5]  = 12'b0_00_000001000; te[5]  = 4'b0000; // MULT
      tw[6]  = 32'h10850004; tc[6]  = 12'b0_00_010000000; te[6]  = 4'b0000; // BEQ
      tw[7]  = 32'h24820004; tc[7]  = 12'b1_00_100000000; te[7]  = 4'b0000; // ADDIU
      tw[8]  = 32'h0000000C; tc[8]  = 12'b0_00_000000000; te[8]  = 4'b0100; // SYSCALL
      tw[9]  = 32'h0000000D; tc[9]  = 12'b0_00_000000000; te[9]  = 4'b0010; // BREAK
      tw[10] = 32'h42000018; tc[10] = 12'b0_00_000000000; te[10] = 4'b0001; // ERET
      for (int i = 0; i < 11; i++) begin
         out_ready = 1'b0; in_valid = 1'b1; in_instr = tw[i]; in_pc = 32'h0000_6000 + 32'(4 * i);
         tick;
         in_valid = 1'b0;
         n_checks++; if (out_ctrl !== tc[i] || out_exc !== te[i] || in_ready !== (te[i] == 4'b0000)) begin n_errors++;
            $display("FAIL decode_%h ctrl=%b exc=%b in_ready=%b exp %b %b %b",
                     tw[i], out_ctrl, out_exc, in_ready, tc[i], te[i], (te[i] == 4'b0000)); end
         out_ready = 1'b1; flush = 1'b1;
         tick;
         out_ready = 1'b0; flush = 1'b0;
      end
   endtask

   task automatic test_mul;
      out_ready = 1'b0; in_valid = 1'b1; in_instr = I_MUL; in_pc = 32'h0000_7000;
      tick;
      in_valid = 1'b0;
`ifdef DECQ_MUL_EN
      n_checks++; if (out_ctrl !== 12'b1_01_000000000 || out_exc !== 4'b0000 || in_ready !== 1'b1) begin n_errors++;
         $display("FAIL mul_en ctrl=%b exc=%b in_ready=%b exp 101000000000 0000 1", out_ctrl, out_exc, in_ready); end
`else
      n_checks++; if (out_ctrl !== 12'h000 || out_exc !== 4'b1000 || in_ready !== 1'b0) begin n_errors++;
         $display("FAIL mul_dis ctrl=%b exc=%b in_ready=%b exp 0 1000 0", out_ctrl, out_exc, in_ready); end
`endif
      out_ready = 1'b1; flush = 1'b1;
      tick;
      out_ready = 1'b0; flush = 1'b0;
   endtask

   task automatic test_async_reset;
      out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ADDU;
      for (int i = 0; i < 3; i++) begin
         in_pc = 32'h0000_8000 + 32'(4 * i);
         tick;
      end
      in_valid = 1'b0;
      n_checks++; if (count !== 3'd3) begin n_errors++; $display("FAIL areset_pre count got=%0d exp=3", count); end
      #2 resetn = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0 || count !== 3'd0 || out_instr !== 32'h0) begin n_errors++;
         $display("FAIL areset count=%0d valid=%b instr=%h exp 0 0 0", count, out_valid, out_instr); end
      @(negedge clk); resetn = 1'b1;
      tick;
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_errors++;
         $display("FAIL areset_release in_ready=%b valid=%b exp 1 0", in_ready, out_valid); end
   endtask

   initial begin
      test_reset;
      test_addu;
      test_full;
      test_back_to_back;
      test_block;
      test_flush_collision;
      test_decode_table;
      test_mul;
      test_async_reset;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DEPTH, default 4, buffered decoded entries; power of two, >=2.
REQ-002 Parameter ADDR_W, default 32, PC width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  fetch presents instruction.
REQ-006 in_ready  output  1  queue accepts this cycle.
REQ-007 in_instr  input  32  MIPS32 instruction word.
REQ-008 in_pc  input  ADDR_W  instruction PC.
REQ-009 flush  input  1  discard all entries, leave BLOCK.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  consumer takes head.
REQ-012 out_instr / out_pc  output  32 / ADDR_W  head instruction and PC.
REQ-013 out_ctrl  output  12  {regwrite, regdst[1:0], alusrc, branch, memwrite, memtoreg, jump, hilo_write, jbral, jr, cp0_write}.
REQ-014 out_exc  output  4  {invalid, syscall, brk, eret} for head.
REQ-015 count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-016 Decode of in_instr SHALL be combinational; the result is written with the instruction on accept (in_valid && in_ready).
REQ-017 Control encodings: ALU R-type and MFHI/MFLO 1_01_000000000; DIV/DIVU/MULT/MULTU/MTHI/MTLO 0_00_000001000; JR 0_00_000000010; JALR 1_01_000000110; I-type ALU 1_00_100000000; BEQ/BNE/BGTZ/BLEZ/BGEZ/BLTZ 0_00_010000000; BGEZAL/BLTZAL 1_10_010000100; loads 1_00_100100000; stores 0_00_101000000; J 0_00_000010000; JAL 1_10_000010100; MTC0 0_00_000000001; MFC0 1_00_000000000; ERET, SYSCALL, BREAK all-zero.
REQ-018 Any other op/funct/rt/rs combination SHALL give ctrl all-zero with exc.invalid=1; SYSCALL, BREAK, ERET set their own exc bit.
REQ-019 Accept-to-out_valid latency SHALL be exactly one cycle when the queue is empty.
REQ-020 Storage is a circular buffer; read/write pointers wrap modulo DEPTH.
REQ-021 in_ready = (state==RUN) && (count<DEPTH); no push while full, even when popping the same cycle.
REQ-022 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-023 out_valid = (count!=0); out_* SHALL hold stable while out_valid && !out_ready.
REQ-024 FSM states RUN, BLOCK; RUN->BLOCK on accepting an entry with any exc bit set; BLOCK->RUN only on flush.
REQ-025 In BLOCK, in_ready=0; buffered entries still drain normally.
REQ-026 flush SHALL win over push and pop in the same cycle: next cycle count=0, pointers=0, state=RUN, same-cycle input dropped.

Reset
REQ-027 On resetn low: count=0, pointers=0, state=RUN, out_valid=0, storage and all out_* cleared to zero, in_ready=1 after release.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Configuration
REQ-029 Macro DECQ_MUL_EN: when defined, SPECIAL2 (op 011100) funct 000010 (MUL) decodes as 1_01_000000000, no exc; when undefined, it decodes as invalid.

Structure
REQ-030 Shared package holds opcode/funct/rt/rs constants, the 12-bit control field positions, the exc bit indices and the FSM state encoding.
REQ-031 Combinational decoder is a sub-module, instr_decode (instr in; ctrl, exc out); queue and FSM live in decode_queue.

Verification
REQ-032 Reset, push 0x00851021 (ADDU), out_ready=1 -> next cycle out_valid=1, ctrl=1_01_000000000, exc=0000.
REQ-033 out_ready=0, DEPTH=4, push 4 LW 0x8C820004 -> count=4, in_ready=0, ctrl=1_00_100100000; then out_ready=1 -> 4 pops in order, PCs preserved.
REQ-034 Push 0x4C000000 -> exc=1000, state BLOCK, in_ready=0; pop; flush -> in_ready=1, count=0.
REQ-035 count=2 with push, pop and flush in the same cycle -> next cycle count=0, out_valid=0, pushed word lost.
REQ-036 Push 0x70851002: with DECQ_MUL_EN -> ctrl=1_01_000000000, exc=0000; without -> exc=1000, BLOCK.
REQ-037 resetn low asynchronously with count=3 -> out_valid=0 and count=0 before the next clk edge.
